// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control unit: six-state one-hot ring counter (T1..T6) and instruction decoder.
// Sequencer state moves on the falling edge so the control word is settled for the rising-edge datapath loads.
module sap1_controller_sequencer (
    input  logic        clk,
    input  logic        sync_reset,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic        cp,
    output logic        ep,
    output logic        low_m_en,
    output logic        low_ce,
    output logic        low_i_en,
    output logic        low_ei,
    output logic        low_a_en,
    output logic        ea,
    output logic        su,
    output logic        eu,
    output logic        low_b_en,
    output logic        low_o_en,
    output logic [5:0]  t_state,
    output logic        halted
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word bit order: {cp, ep, low_m_en, low_ce, low_i_en, low_ei, low_a_en, ea, su, eu, low_b_en, low_o_en}
    localparam logic [11:0] CON_IDLE = 12'h3E3;
    localparam logic [11:0] CON_T1   = 12'h5E3;
    localparam logic [11:0] CON_T2   = 12'hBE3;
    localparam logic [11:0] CON_T3   = 12'h263;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_e;

    ring_e state;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(negedge clk) begin
        if (sync_reset) begin
            state  <= T1;
            halted <= 1'b0;
        end else if (!halted) begin
            if (state == T4 && opcode == OP_HLT) begin
                halted <= 1'b1;
            end else begin
                case (state)
                    T1:      state <= T2;
                    T2:      state <= T3;
                    T3:      state <= T4;
                    T4:      state <= T5;
                    T5:      state <= T6;
                    T6:      state <= T1;
                    default: state <= T1;
                endcase
            end
        end
    end

    assign t_state = state;

    // NOTE: con gets its idle default first so no path through the decoder can infer a latch.
    always_comb begin
        con = CON_IDLE;
        if (!halted) begin
            case (state)
                T1: con = CON_T1;
                T2: con = CON_T2;
                T3: con = CON_T3;
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: con = 12'h1A3;
                        OP_OUT:                 con = 12'h3F2;
                        default:                con = CON_IDLE;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         con = 12'h2C3;
                        OP_ADD, OP_SUB: con = 12'h2E1;
                        default:        con = CON_IDLE;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_LDA:  con = 12'h3E3;
                        OP_ADD:  con = 12'h3C7;
                        OP_SUB:  con = 12'h3CF;
                        default: con = CON_IDLE;
                    endcase
                end
                default: con = CON_IDLE;
            endcase
        end
    end

    assign {cp, ep, low_m_en, low_ce, low_i_en, low_ei,
            low_a_en, ea, su, eu, low_b_en, low_o_en} = con;

endmodule
